// File: rtl/stack_calc_pkg.sv
// Shared types and per-op operand requirements for the stack_calc arithmetic core.
package stack_calc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_NEG  = 3'd2,
        OP_ADD  = 3'd3,
        OP_MUL  = 3'd4,
        OP_SUB  = 3'd5,
        OP_SWAP = 3'd6,
        OP_POP  = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Minimum stack elements required, indexed by opcode value.
    localparam logic [1:0] MIN_ARGS [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

endpackage

// File: rtl/stack_calc_if.sv
// Command/status bundle between the lab front-end (master) and stack_calc (slave).
interface stack_calc_if
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             valid;
    op_t              op;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] out;
    logic             err_ovf;
    logic             err_unf;

    modport master (output valid, op, d, input busy, cnt, out, err_ovf, err_unf);
    modport slave  (input valid, op, d, output busy, cnt, out, err_ovf, err_unf);
endinterface

// File: rtl/stack_calc_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of a*b.
module stack_calc_mul
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             step,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int IW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic             r_busy;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [IW-1:0]    r_iter;

    logic [WIDTH-1:0] w_sum;
    logic [IW-1:0]    w_iter_nxt;

    // The final step's sum is presented combinationally so the top register
    // loads the product on the same edge the iteration counter reaches WIDTH.
    assign w_sum      = r_acc + (r_b[0] ? r_a : '0);
    assign w_iter_nxt = r_iter + 1'b1;
    assign done       = (r_state == S_MUL) && (w_iter_nxt == IW'(WIDTH));
    assign p          = w_sum;
    assign busy       = r_busy;

    always_ff @(posedge step or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc  <= w_sum;
                    r_a    <= r_a << 1;
                    r_b    <= r_b >> 1;
                    r_iter <= w_iter_nxt;
                    if (done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/stack_calc.sv
// Stack-machine arithmetic core: top register, spill array, op decode and sticky error flags.
module stack_calc
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic         step,
    input  logic         rst,
    stack_calc_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    logic [WIDTH-1:0] r_top;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_mem [DEPTH-1];

    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_prod;
    logic             w_start;
    logic             w_accept;
    logic             w_has_args;
    logic             w_full;
    logic [AW-1:0]    w_s_idx;
    logic [AW-1:0]    w_push_idx;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_top_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_idx;
    logic [WIDTH-1:0] w_mem_wd;

    stack_calc_mul #(.WIDTH(WIDTH)) u_mul (
        .step  (step),
        .rst   (rst),
        .start (w_start),
        .a     (w_s),
        .b     (r_top),
        .busy  (w_busy),
        .done  (w_done),
        .p     (w_prod)
    );

    assign w_s_idx    = AW'(r_cnt - CNT_W'(2));
    assign w_push_idx = AW'(r_cnt - CNT_W'(1));
    assign w_s        = r_mem[w_s_idx];
    assign w_accept   = bus.valid && !w_busy;
    assign w_has_args = r_cnt >= CNT_W'(MIN_ARGS[bus.op]);
    assign w_full     = r_cnt == CNT_W'(DEPTH);

    always_comb begin
        w_top_nxt = r_top;
        w_cnt_nxt = r_cnt;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_idx = w_push_idx;
        w_mem_wd  = r_top;
        w_start   = 1'b0;
        if (w_done) begin
            w_top_nxt = w_prod;
            w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_accept) begin
            if (bus.op == OP_PUSH) begin
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_mem_we  = (r_cnt != '0);
                    w_top_nxt = bus.d;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else if (!w_has_args) begin
                w_set_unf = 1'b1;
            end else begin
                case (bus.op)
                    OP_NEG: w_top_nxt = -r_top;
                    OP_ADD: begin
                        w_top_nxt = w_s + r_top;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                    OP_SUB: begin
                        w_top_nxt = w_s - r_top;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                    OP_MUL: w_start = 1'b1;
                    OP_SWAP: begin
                        w_mem_we  = 1'b1;
                        w_mem_idx = w_s_idx;
                        w_top_nxt = w_s;
                    end
                    OP_POP: begin
                        w_top_nxt = (r_cnt >= CNT_W'(2)) ? w_s : '0;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge step or posedge rst) begin
        if (rst) begin
            r_top <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_top <= w_top_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_set_ovf;
            r_unf <= r_unf | w_set_unf;
        end
    end

    // Array is deliberately unreset; entries are unreachable while cnt==0.
    always_ff @(posedge step) begin
        if (w_mem_we && !rst) r_mem[w_mem_idx] <= w_mem_wd;
    end

    assign bus.busy    = w_busy;
    assign bus.cnt     = r_cnt;
    assign bus.out     = (r_cnt == '0) ? '0 : r_top;
    assign bus.err_ovf = r_ovf;
    assign bus.err_unf = r_unf;
endmodule

// File: tb/tb_stack_calc.sv
// Directed self-checking bench for stack_calc with WIDTH=16, DEPTH=4.
module tb_stack_calc;
    import stack_calc_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic step;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_busy;

    stack_calc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .step (step),
        .rst  (rst),
        .bus  (bus)
    );

    initial step = 1'b0;
    always #5 step = ~step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.valid = 1'b0;
        @(negedge step);
        @(negedge step);
        rst = 1'b0;
    endtask

    task automatic cmd(input op_t op, input logic [WIDTH-1:0] d);
        @(negedge step);
        bus.valid = 1'b1;
        bus.op    = op;
        bus.d     = d;
        @(negedge step);
        bus.valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        bus.valid = 1'b0;
        bus.op    = OP_NOP;
        bus.d     = '0;
        rst       = 1'b0;

        // 1: reset state and basic ADD
        do_reset();
        chk("rst_cnt",  32'(bus.cnt), 0);
        chk("rst_out",  32'(bus.out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovf",  32'(bus.err_ovf), 0);
        chk("rst_unf",  32'(bus.err_unf), 0);
        cmd(OP_PUSH, 16'd5);
        cmd(OP_PUSH, 16'hFFFD);
        chk("push_out", 32'(bus.out), 32'h0000FFFD);
        chk("push_cnt", 32'(bus.cnt), 2);
        cmd(OP_ADD, '0);
        chk("add_out", 32'(bus.out), 2);
        chk("add_cnt", 32'(bus.cnt), 1);

        // 2: SUB, SWAP underflow, recovery
        do_reset();
        cmd(OP_PUSH, 16'd7);
        cmd(OP_PUSH, 16'd10);
        cmd(OP_SUB, '0);
        chk("sub_out", 32'(bus.out), 32'h0000FFFD);
        chk("sub_cnt", 32'(bus.cnt), 1);
        cmd(OP_SWAP, '0);
        chk("unf_flag", 32'(bus.err_unf), 1);
        chk("unf_out",  32'(bus.out), 32'h0000FFFD);
        chk("unf_cnt",  32'(bus.cnt), 1);
        cmd(OP_PUSH, 16'd1);
        chk("after_unf_out", 32'(bus.out), 1);
        chk("after_unf_cnt", 32'(bus.cnt), 2);
        cmd(OP_NOP, 16'd55);
        chk("nop_out", 32'(bus.out), 1);
        chk("nop_unf_sticky", 32'(bus.err_unf), 1);

        // 2b: SWAP exchanges T and S
        do_reset();
        cmd(OP_PUSH, 16'd1);
        cmd(OP_PUSH, 16'd2);
        cmd(OP_SWAP, '0);
        chk("swap_out", 32'(bus.out), 1);
        chk("swap_cnt", 32'(bus.cnt), 2);
        cmd(OP_POP, '0);
        chk("swap_pop", 32'(bus.out), 2);

        // 3: overflow and drain
        do_reset();
        cmd(OP_PUSH, 16'd1);
        cmd(OP_PUSH, 16'd2);
        cmd(OP_PUSH, 16'd3);
        cmd(OP_PUSH, 16'd4);
        chk("full_cnt", 32'(bus.cnt), 4);
        cmd(OP_PUSH, 16'd9);
        chk("ovf_flag", 32'(bus.err_ovf), 1);
        chk("ovf_cnt",  32'(bus.cnt), 4);
        chk("ovf_out",  32'(bus.out), 4);
        cmd(OP_POP, '0);
        chk("pop1", 32'(bus.out), 3);
        cmd(OP_POP, '0);
        chk("pop2", 32'(bus.out), 2);
        cmd(OP_POP, '0);
        chk("pop3", 32'(bus.out), 1);
        cmd(OP_POP, '0);
        chk("pop4", 32'(bus.out), 0);
        chk("pop_cnt", 32'(bus.cnt), 0);
        cmd(OP_NEG, '0);
        chk("empty_neg_unf", 32'(bus.err_unf), 1);

        // 4: MUL latency, hold, dropped command
        do_reset();
        cmd(OP_PUSH, 16'hFFFA);
        cmd(OP_PUSH, 16'd7);
        cmd(OP_MUL, '0);
        chk("mul_hold_cnt", 32'(bus.cnt), 2);
        chk("mul_hold_out", 32'(bus.out), 7);
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            n_busy++;
            if (n_busy == 3) begin
                bus.valid = 1'b1;
                bus.op    = OP_PUSH;
                bus.d     = 16'd99;
            end else begin
                bus.valid = 1'b0;
            end
            @(negedge step);
        end
        bus.valid = 1'b0;
        chk("mul_busy_cycles", 32'(n_busy), 16);
        chk("mul_out", 32'(bus.out), 32'h0000FFD6);
        chk("mul_cnt", 32'(bus.cnt), 1);
        chk("mul_no_ovf", 32'(bus.err_ovf), 0);

        // 5: wraparound MUL and NEG of most negative value
        do_reset();
        cmd(OP_PUSH, 16'h7FFF);
        cmd(OP_PUSH, 16'd2);
        cmd(OP_MUL, '0);
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            @(negedge step);
        end
        chk("mul_wrap_out", 32'(bus.out), 32'h0000FFFE);
        cmd(OP_PUSH, 16'h8000);
        cmd(OP_NEG, '0);
        chk("neg_min", 32'(bus.out), 32'h00008000);
        chk("neg_min_cnt", 32'(bus.cnt), 2);

        // 6: asynchronous abort mid-MUL
        do_reset();
        cmd(OP_PUSH, 16'd3);
        cmd(OP_PUSH, 16'd4);
        cmd(OP_MUL, '0);
        repeat (4) @(negedge step);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_cnt",  32'(bus.cnt), 0);
        chk("abort_out",  32'(bus.out), 0);
        #1 rst = 1'b0;
        cmd(OP_PUSH, 16'd1);
        chk("abort_push_out", 32'(bus.out), 1);
        chk("abort_push_cnt", 32'(bus.cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
